// File: rtl/pipe_bpred.sv
// Direct-mapped branch target buffer with saturating direction counters and
// a self-clearing INIT sweep. Define BPRED_GSHARE_EN to XOR global history into the index.
module pipe_bpred #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  output logic            ready,
  input  logic            u_valid,
  input  logic [XLEN-1:0] u_pc,
  input  logic            u_isB,
  input  logic            u_taken,
  input  logic [XLEN-1:0] u_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [IW-1:0]    LAST_IDX = IW'(ENTRIES - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [IW-1:0] sweep_idx;

  logic             vld     [ENTRIES];
  logic [TW-1:0]    tag_mem [ENTRIES];
  logic [XLEN-1:0]  tgt_mem [ENTRIES];
  logic [CTR_W-1:0] ctr_mem [ENTRIES];

  logic [IW-1:0]    f_idx, u_idx;
  logic [TW-1:0]    f_tag, u_tag;
  logic             f_hit, u_hit, upd;
  logic [CTR_W-1:0] ctr_cur, ctr_next;

  assign f_tag = f_pc[XLEN-1:IW+2];
  assign u_tag = u_pc[XLEN-1:IW+2];
  assign upd   = resetn && (state == RUN) && u_valid;

`ifdef BPRED_GSHARE_EN
  logic [IW-1:0] ghist;

  always_ff @(posedge clk) begin
    if (!resetn)
      ghist <= '0;
    else if (upd && u_isB)
      ghist <= (ghist << 1) | IW'(u_taken);
  end

  assign f_idx = f_pc[IW+1:2] ^ ghist;
  assign u_idx = u_pc[IW+1:2] ^ ghist;
`else
  assign f_idx = f_pc[IW+1:2];
  assign u_idx = u_pc[IW+1:2];
`endif

  // Word-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], u_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= INIT;
      sweep_idx <= '0;
      ready     <= 1'b0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == LAST_IDX) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Reads see pre-update contents, so a same-cycle update is visible next cycle.
  assign f_hit    = ready && vld[f_idx] && (tag_mem[f_idx] == f_tag);
  assign p_taken  = f_hit && ctr_mem[f_idx][CTR_W-1];
  assign p_target = p_taken ? tgt_mem[f_idx] : f_pc + XLEN'(4);

  assign u_hit = vld[u_idx] && (tag_mem[u_idx] == u_tag);

  always_comb begin
    ctr_cur  = ctr_mem[u_idx];
    ctr_next = ctr_cur;
    if (!u_isB)
      ctr_next = CTR_MAX;
    else if (u_taken && (ctr_cur != CTR_MAX))
      ctr_next = ctr_cur + 1'b1;
    else if (!u_taken && (ctr_cur != '0))
      ctr_next = ctr_cur - 1'b1;
  end

  // NOTE: the table has no reset branch; the INIT sweep clears it one index per cycle.
  always_ff @(posedge clk) begin
    if (resetn && (state == INIT)) begin
      vld[sweep_idx]     <= 1'b0;
      ctr_mem[sweep_idx] <= CTR_INIT;
    end else if (upd) begin
      if (u_hit) begin
        ctr_mem[u_idx] <= ctr_next;
        if (u_taken)
          tgt_mem[u_idx] <= u_target;
      end else if (u_taken) begin
        vld[u_idx]     <= 1'b1;
        tag_mem[u_idx] <= u_tag;
        tgt_mem[u_idx] <= u_target;
        ctr_mem[u_idx] <= u_isB ? CTR_WEAK : CTR_MAX;
      end
    end
  end

endmodule

// File: tb/tb_pipe_bpred.sv
// Self-checking bench for pipe_bpred (ENTRIES=64, CTR_W=2, no gshare): directed
// scenarios with literal expectations plus randomized traffic against a table model.
module tb_pipe_bpred;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] f_pc;
  logic        p_taken;
  logic [31:0] p_target;
  logic        ready;
  logic        u_valid;
  logic [31:0] u_pc;
  logic        u_isB;
  logic        u_taken;
  logic [31:0] u_target;

  int n_total = 0;
  int n_pass  = 0;

  pipe_bpred #(.XLEN(32), .ENTRIES(N), .CTR_W(2)) dut (
    .clk(clk), .resetn(resetn), .f_pc(f_pc), .p_taken(p_taken),
    .p_target(p_target), .ready(ready), .u_valid(u_valid), .u_pc(u_pc),
    .u_isB(u_isB), .u_taken(u_taken), .u_target(u_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Behavioural model: a plain table plus a count of cycles since reset.
  bit          m_known = 0;
  bit          m_ready;
  int          m_cnt;
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_step();
    int i;
    if (!resetn) begin
      m_known = 1;
      m_ready = 0;
      m_cnt   = 0;
    end else if (m_known) begin
      if (m_ready && u_valid) begin
        i = idx_of(u_pc);
        if (m_valid[i] && m_tag[i] == (u_pc >> 8)) begin
          if (!u_isB)       m_ctr[i] = 3;
          else if (u_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          else              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          if (u_taken) m_tgt[i] = u_target;
        end else if (u_taken) begin
          m_valid[i] = 1;
          m_tag[i]   = u_pc >> 8;
          m_tgt[i]   = u_target;
          m_ctr[i]   = u_isB ? 2 : 3;
        end
      end
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_ready = 1;
          for (int k = 0; k < N; k++) begin
            m_valid[k] = 0;
            m_ctr[k]   = 1;
          end
        end
      end
    end
  endtask

  task automatic model_compare();
    int          i;
    bit          e_taken;
    logic [31:0] e_target;
    i        = idx_of(f_pc);
    e_taken  = m_ready && m_valid[i] && (m_tag[i] == (f_pc >> 8)) && (m_ctr[i] >= 2);
    e_target = e_taken ? m_tgt[i] : f_pc + 32'd4;
    check("model_ready", {31'd0, ready}, {31'd0, m_ready});
    check("model_p_taken", {31'd0, p_taken}, {31'd0, e_taken});
    check("model_p_target", p_target, e_target);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_known) model_compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic isb, input logic tk, input logic [31:0] tgt);
    u_valid  = 1'b1;
    u_pc     = pc;
    u_isB    = isb;
    u_taken  = tk;
    u_target = tgt;
    tick();
    u_valid = 1'b0;
  endtask

  task automatic probe(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    #1;
    f_pc = pc;
    #1;
    check({name, "_taken"}, {31'd0, p_taken}, {31'd0, tk});
    check({name, "_target"}, p_target, tgt);
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    resetn = 1'b0; f_pc = 32'h100; u_valid = 1'b0;
    u_pc = '0; u_isB = 1'b0; u_taken = 1'b0; u_target = '0;
    tick();
    resetn = 1'b1;

    // Reset sweep: 64 cycles not ready, fall-through prediction.
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      check("init_ready", {31'd0, ready}, 32'd0);
      check("init_p_taken", {31'd0, p_taken}, 32'd0);
      check("init_p_target", p_target, 32'h104);
      tick();
    end
    @(negedge clk);
    check("ready_after_sweep", {31'd0, ready}, 32'd1);
    tick();

    probe("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    upd(32'h100, 1'b1, 1'b1, 32'h80);
    probe("train", 32'h100, 1'b1, 32'h80);

    upd(32'h100, 1'b1, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 1'b0, 32'h0);
    probe("sat_dec", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 1'b1, 32'h80);
    probe("sat_floor", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 1'b1, 32'h80);
    probe("sat_inc", 32'h100, 1'b1, 32'h80);

    probe("alias_miss", 32'h1100, 1'b0, 32'h1104);
    upd(32'h1100, 1'b1, 1'b1, 32'h500);
    probe("alias_new", 32'h1100, 1'b1, 32'h500);
    probe("alias_evicted", 32'h100, 1'b0, 32'h104);

    // Same-cycle predict and update: old contents now, new contents next cycle.
    @(negedge clk); #1;
    f_pc = 32'h200;
    u_valid = 1'b1; u_pc = 32'h200; u_isB = 1'b1; u_taken = 1'b1; u_target = 32'h40;
    #1;
    check("same_cycle_before", {31'd0, p_taken}, 32'd0);
    tick();
    u_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_after_taken", {31'd0, p_taken}, 32'd1);
    check("same_cycle_after_target", p_target, 32'h40);
    tick();

    upd(32'h300, 1'b0, 1'b1, 32'h1234);
    upd(32'h300, 1'b1, 1'b0, 32'h0);
    probe("jump_strong", 32'h300, 1'b1, 32'h1234);

    // Mid-run reset discards training; updates during the sweep are ignored.
    upd(32'h100, 1'b1, 1'b1, 32'h80);
    probe("pre_reset", 32'h100, 1'b1, 32'h80);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      check("rerun_ready", {31'd0, ready}, 32'd0);
      if (c == 10) begin
        #1;
        u_valid = 1'b1; u_pc = 32'h100; u_isB = 1'b1; u_taken = 1'b1; u_target = 32'h80;
      end
      tick();
      u_valid = 1'b0;
    end
    probe("post_reset", 32'h100, 1'b0, 32'h104);

    // Randomized traffic; the model compare runs every cycle.
    for (int c = 0; c < 3000; c++) begin
      resetn   = ($urandom_range(0, 399) != 0);
      f_pc     = rand_pc();
      u_valid  = $urandom_range(0, 1) == 1;
      u_pc     = ($urandom_range(0, 1) == 1) ? f_pc : rand_pc();
      u_isB    = $urandom_range(0, 3) != 0;
      u_taken  = $urandom_range(0, 1) == 1;
      u_target = $urandom;
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
